// File: rtl/cam_capture_ctrl_mf_pkg.sv
// Shared types for the multi-frame camera capture controller.
package cam_pkg;
    localparam int PIX_W_DEF = 12;
    localparam int PPC_DEF   = 4;

    typedef enum logic [2:0] {
        IDLE, WAIT_EOF, WAIT_SOF, CAP, DONE
    } cap_state_e;

    typedef enum logic [1:0] {
        TM_GRAD     = 2'd0,
        TM_CHECK    = 2'd1,
        TM_FLAT     = 2'd2,
        TM_GRAD_ALT = 2'd3
    } test_mode_e;

    typedef enum logic [1:0] {
        TG_IDLE, TG_SOF, TG_GAP, TG_BEAT
    } tpg_state_e;
endpackage

// File: rtl/cam_capture_ctrl_mf_if.sv
// Camera-side input beat and forwarded output beat bundle.
interface cam_capture_ctrl_mf_if #(
    parameter int PIX_W = 12,
    parameter int PPC   = 4
);
    logic                   cl_frame_valid;
    logic                   cl_new_frame;
    logic                   cl_pix_vld;
    logic [PIX_W*PPC-1:0]   cl_pixel;
    logic [PIX_W*PPC-1:0]   out_pixel;
    logic                   out_vld;
    logic                   out_sof;
    logic                   out_eol;
    logic                   out_eof;

    modport master (
        output cl_frame_valid, cl_new_frame, cl_pix_vld, cl_pixel,
        input  out_pixel, out_vld, out_sof, out_eol, out_eof
    );
    modport slave (
        input  cl_frame_valid, cl_new_frame, cl_pix_vld, cl_pixel,
        output out_pixel, out_vld, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/cam_test_pattern_gen.sv
// Built-in frame source: SOF pulse, then per line a gap and a burst of beats.
module cam_test_pattern_gen
    import cam_pkg::*;
#(
    parameter int PIX_W    = 12,
    parameter int PPC      = 4,
    parameter int DIM_W    = 16,
    parameter int LINE_GAP = 255
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 abort,
    input  test_mode_e           mode,
    input  logic [DIM_W-1:0]     width,
    input  logic [DIM_W-1:0]     height,
    output logic                 frame_valid,
    output logic                 new_frame,
    output logic                 pix_vld,
    output logic [PIX_W*PPC-1:0] pixel
);
    localparam int GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
    localparam logic [DIM_W-1:0] PPC_D = DIM_W'(PPC);
    localparam tpg_state_e GAP_ST = (LINE_GAP == 0) ? TG_BEAT : TG_GAP;

    tpg_state_e       st;
    test_mode_e       md;
    logic [GW-1:0]    gap;
    logic [DIM_W-1:0] col, line, wlim, hlim, lc;
    logic             cb;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            st   <= TG_IDLE;
            md   <= TM_GRAD;
            gap  <= '0;
            col  <= '0;
            line <= '0;
            wlim <= '0;
            hlim <= '0;
        end else if (abort) begin
            st <= TG_IDLE;
        end else if (start) begin
            st   <= TG_SOF;
            md   <= mode;
            gap  <= '0;
            col  <= '0;
            line <= '0;
            wlim <= width - PPC_D;
            hlim <= height - DIM_W'(1);
        end else begin
            unique case (st)
                TG_SOF: st <= GAP_ST;
                TG_GAP: begin
                    if (gap == GW'(LINE_GAP - 1)) begin
                        gap <= '0;
                        st  <= TG_BEAT;
                    end else begin
                        gap <= gap + GW'(1);
                    end
                end
                TG_BEAT: begin
                    if (col == wlim) begin
                        col <= '0;
                        if (line == hlim) begin
                            st <= TG_IDLE;
                        end else begin
                            line <= line + DIM_W'(1);
                            st   <= GAP_ST;
                        end
                    end else begin
                        col <= col + PPC_D;
                    end
                end
                default: ;
            endcase
        end
    end

    assign frame_valid = (st != TG_IDLE);
    assign new_frame   = (st == TG_SOF);
    assign pix_vld     = (st == TG_BEAT);

    always_comb begin
        pixel = '0;
        lc    = '0;
        cb    = 1'b0;
        for (int k = 0; k < PPC; k++) begin
            lc = col + DIM_W'(k);
            cb = line[3] ^ lc[3];
            unique case (md)
                TM_CHECK: pixel[k*PIX_W +: PIX_W] = {PIX_W{cb}};
                TM_FLAT:  pixel[k*PIX_W +: PIX_W] = '1;
                default:  pixel[k*PIX_W +: PIX_W] = PIX_W'(line + lc);
            endcase
        end
    end
endmodule

// File: rtl/cam_capture_ctrl_mf.sv
// Multi-frame capture controller: arms, syncs to a frame boundary, forwards N frames.
module cam_capture_ctrl_mf
    import cam_pkg::*;
#(
    parameter int PIX_W    = PIX_W_DEF,
    parameter int PPC      = PPC_DEF,
    parameter int DIM_W    = 16,
    parameter int LINE_GAP = 255
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    cam_capture_ctrl_mf_if.slave bus,
    input  logic [DIM_W-1:0] img_width,
    input  logic [DIM_W-1:0] img_height,
    input  logic [DIM_W-1:0] frame_count,
    input  logic             test_en,
    input  logic [1:0]       test_mode,
    input  logic             capture,
    input  logic             stop,
    output logic             busy,
    output logic             capture_end,
    output logic [DIM_W-1:0] frames_done,
    output logic             frame_err
);
    localparam int BW = PIX_W * PPC;
    localparam logic [DIM_W-1:0] PPC_D = DIM_W'(PPC);

    cap_state_e       state, state_n;
    logic             src_test, stop_pend;
    logic [DIM_W-1:0] col, line, wlim, hlim, fd_inc;
    logic             fv, nf, pv, arm_fv;
    logic [BW-1:0]    px;
    logic             t_fv, t_nf, t_pv, t_start, t_abort;
    logic [BW-1:0]    t_px;
    logic             is_eol, is_eof, eof_beat, abort_frm, fwd, fin, restart;

    cam_test_pattern_gen #(
        .PIX_W(PIX_W), .PPC(PPC), .DIM_W(DIM_W), .LINE_GAP(LINE_GAP)
    ) u_tpg (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (t_start),
        .abort       (t_abort),
        .mode        (test_mode_e'(test_mode)),
        .width       (img_width),
        .height      (img_height),
        .frame_valid (t_fv),
        .new_frame   (t_nf),
        .pix_vld     (t_pv),
        .pixel       (t_px)
    );

    assign fv     = src_test ? t_fv : bus.cl_frame_valid;
    assign nf     = src_test ? t_nf : bus.cl_new_frame;
    assign pv     = src_test ? t_pv : bus.cl_pix_vld;
    assign px     = src_test ? t_px : bus.cl_pixel;
    assign arm_fv = test_en ? t_fv : bus.cl_frame_valid;

    assign is_eol = (col == wlim);
    assign is_eof = is_eol && (line == hlim);
    assign fd_inc = (&frames_done) ? frames_done : frames_done + DIM_W'(1);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (capture) state_n = arm_fv ? WAIT_EOF : WAIT_SOF;
            WAIT_EOF: if (stop) state_n = DONE;
                      else if (!fv) state_n = WAIT_SOF;
            WAIT_SOF: if (stop) state_n = DONE;
                      else if (nf) state_n = CAP;
            CAP:      if (eof_beat) state_n = fin ? DONE : WAIT_SOF;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // eof wins over a coincident new_frame; that new_frame is dropped
    always_comb begin
        busy        = (state != IDLE);
        capture_end = (state == DONE);
        t_abort     = (state == DONE);
        eof_beat    = (state == CAP) && pv && is_eof;
        abort_frm   = (state == CAP) && nf && !eof_beat;
        fwd         = (state == CAP) && pv && !abort_frm;
        fin         = eof_beat && (stop_pend || stop ||
                      ((frame_count != '0) && (fd_inc == frame_count)));
        restart     = abort_frm || ((state == WAIT_SOF) && (state_n == CAP));
        t_start     = (state_n == WAIT_SOF) && (state != WAIT_SOF) &&
                      ((state == IDLE) ? test_en : src_test);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.out_pixel <= '0;
            bus.out_vld   <= 1'b0;
            bus.out_sof   <= 1'b0;
            bus.out_eol   <= 1'b0;
            bus.out_eof   <= 1'b0;
            src_test      <= 1'b0;
            stop_pend     <= 1'b0;
            col           <= '0;
            line          <= '0;
            wlim          <= '0;
            hlim          <= '0;
            frames_done   <= '0;
            frame_err     <= 1'b0;
        end else begin
            bus.out_vld <= fwd;
            bus.out_sof <= fwd && (col == '0) && (line == '0);
            bus.out_eol <= fwd && is_eol;
            bus.out_eof <= fwd && is_eof;
            if (fwd) bus.out_pixel <= px;
            if (state == IDLE && capture) begin
                src_test    <= test_en;
                frames_done <= '0;
                frame_err   <= 1'b0;
            end
            if (state == DONE) begin
                src_test  <= 1'b0;
                stop_pend <= 1'b0;
            end
            if (state == CAP && stop) stop_pend <= 1'b1;
            if (abort_frm) frame_err <= 1'b1;
            if (eof_beat) frames_done <= fd_inc;
            if (restart) begin
                col  <= '0;
                line <= '0;
                wlim <= img_width - PPC_D;
                hlim <= img_height - DIM_W'(1);
            end else if (fwd) begin
                if (is_eol) begin
                    col  <= '0;
                    line <= line + DIM_W'(1);
                end else begin
                    col <= col + PPC_D;
                end
            end
        end
    end
endmodule

// File: tb/tb_cam_capture_ctrl_mf.sv
// Scoreboard bench for the multi-frame capture controller.
module tb_cam_capture_ctrl_mf;
    localparam int PIX_W    = 12;
    localparam int PPC      = 4;
    localparam int DIM_W    = 16;
    localparam int LINE_GAP = 255;
    localparam int BW       = PIX_W * PPC;

    typedef struct packed {
        logic [BW-1:0] pix;
        logic sof;
        logic eol;
        logic eof;
    } beat_t;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [DIM_W-1:0] img_width = '0, img_height = '0, frame_count = '0;
    logic             test_en = 1'b0;
    logic [1:0]       test_mode = 2'd0;
    logic             capture = 1'b0, stop = 1'b0;
    logic             busy, capture_end, frame_err;
    logic [DIM_W-1:0] frames_done;

    int    checks = 0, errors = 0, cyc = 0, ce_cnt = 0, beats = 0;
    int    ce0, b0, t0, t1, t2;
    beat_t exp_q[$];
    beat_t mon_got, mon_exp;

    cam_capture_ctrl_mf_if #(.PIX_W(PIX_W), .PPC(PPC)) bus();

    cam_capture_ctrl_mf #(
        .PIX_W(PIX_W), .PPC(PPC), .DIM_W(DIM_W), .LINE_GAP(LINE_GAP)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .img_width   (img_width),
        .img_height  (img_height),
        .frame_count (frame_count),
        .test_en     (test_en),
        .test_mode   (test_mode),
        .capture     (capture),
        .stop        (stop),
        .busy        (busy),
        .capture_end (capture_end),
        .frames_done (frames_done),
        .frame_err   (frame_err)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc++;

    // monitor: every forwarded beat is checked against the scoreboard queue
    always @(negedge sys_clk) begin
        if (!sys_rst && bus.out_vld) begin
            beats++;
            checks++;
            mon_got = '{bus.out_pixel, bus.out_sof, bus.out_eol, bus.out_eof};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL beat_unexpected: got pix=%h flags=%b%b%b",
                         mon_got.pix, mon_got.sof, mon_got.eol, mon_got.eof);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL beat %0d: got pix=%h sof/eol/eof=%b%b%b, expected pix=%h sof/eol/eof=%b%b%b",
                             beats, mon_got.pix, mon_got.sof, mon_got.eol, mon_got.eof,
                             mon_exp.pix, mon_exp.sof, mon_exp.eol, mon_exp.eof);
                end
            end
        end
        if (!sys_rst && capture_end) ce_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint got, input longint expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
        end
    endtask

    function automatic logic [BW-1:0] pk(input int s);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < PPC; k++) v[k*PIX_W +: PIX_W] = PIX_W'(s + k);
        return v;
    endfunction

    // one camera frame; lane k of beat b carries base+b*PPC+k
    task automatic cam_frame(input int w, input int h, input int base, input bit fwd,
                             input int nsend, input int cap_at, input int stop_at);
        int bpl;
        int nb;
        int n;
        logic [BW-1:0] p;
        bpl = w / PPC;
        nb  = bpl * h;
        n   = (nsend < 0) ? nb : nsend;
        bus.cl_frame_valid = 1'b1;
        bus.cl_new_frame   = 1'b1;
        tick();
        bus.cl_new_frame = 1'b0;
        tick();
        for (int b = 0; b < n; b++) begin
            p = pk(base + b * PPC);
            bus.cl_pix_vld = 1'b1;
            bus.cl_pixel   = p;
            capture = (b == cap_at);
            stop    = (b == stop_at);
            if (fwd) exp_q.push_back('{p, b == 0, (b % bpl) == bpl - 1, b == nb - 1});
            tick();
        end
        bus.cl_pix_vld = 1'b0;
        capture = 1'b0;
        stop    = 1'b0;
        if (nsend < 0) begin
            bus.cl_frame_valid = 1'b0;
            tick();
        end
    endtask

    task automatic pulse_capture();
        capture = 1'b1;
        tick();
        capture = 1'b0;
    endtask

    task automatic wait_vld(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (bus.out_vld) begin
                at = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_vld: no beat within %0d cycles", budget);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge sys_clk);
            if (!busy) begin
                tick();
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
    endtask

    initial begin
        bus.cl_frame_valid = 1'b0;
        bus.cl_new_frame   = 1'b0;
        bus.cl_pix_vld     = 1'b0;
        bus.cl_pixel       = '0;
        repeat (3) tick();
        chk("rst_out_vld", bus.out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_capture_end", capture_end, 0);
        chk("rst_frames_done", frames_done, 0);
        chk("rst_frame_err", frame_err, 0);
        sys_rst = 1'b0;
        tick();

        // 1: camera 16x2, one frame, armed while frame_valid low
        img_width = 16; img_height = 2; frame_count = 1;
        ce0 = ce_cnt; b0 = beats;
        pulse_capture();
        chk("t1_busy_armed", busy, 1);
        cam_frame(16, 2, 'h100, 1, -1, -1, -1);
        tick();
        chk("t1_beats", beats - b0, 8);
        chk("t1_capture_end", ce_cnt - ce0, 1);
        chk("t1_frames_done", frames_done, 1);
        chk("t1_busy_idle", busy, 0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // 2: armed mid-frame, that frame is skipped
        ce0 = ce_cnt; b0 = beats;
        cam_frame(16, 2, 'h200, 0, -1, 2, -1);
        chk("t2_busy_wait", busy, 1);
        chk("t2_frames_cleared", frames_done, 0);
        cam_frame(16, 2, 'h300, 1, -1, -1, -1);
        tick();
        chk("t2_beats", beats - b0, 8);
        chk("t2_capture_end", ce_cnt - ce0, 1);
        chk("t2_frames_done", frames_done, 1);

        // 3: test source, gradient 8x2, three frames
        img_width = 8; img_height = 2; frame_count = 3;
        test_en = 1'b1; test_mode = 2'd0;
        ce0 = ce_cnt; b0 = beats;
        for (int f = 0; f < 3; f++) begin
            exp_q.push_back('{pk(0), 1'b1, 1'b0, 1'b0});
            exp_q.push_back('{pk(4), 1'b0, 1'b1, 1'b0});
            exp_q.push_back('{pk(1), 1'b0, 1'b0, 1'b0});
            exp_q.push_back('{pk(5), 1'b0, 1'b1, 1'b1});
        end
        pulse_capture();
        test_en = 1'b0;
        wait_vld(2000, t0);
        wait_vld(10, t1);
        wait_vld(2000, t2);
        chk("t3_line_burst", t1 - t0, 1);
        chk("t3_line_gap", t2 - t1, LINE_GAP + 1);
        wait_idle(5000);
        chk("t3_beats", beats - b0, 12);
        chk("t3_capture_end", ce_cnt - ce0, 1);
        chk("t3_frames_done", frames_done, 3);
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4a: continuous, stop during frame 2
        img_width = 8; img_height = 1; frame_count = 0;
        ce0 = ce_cnt; b0 = beats;
        pulse_capture();
        cam_frame(8, 1, 'h400, 1, -1, -1, -1);
        chk("t4a_busy_after_f1", busy, 1);
        cam_frame(8, 1, 'h500, 1, -1, -1, 0);
        tick();
        chk("t4a_beats", beats - b0, 4);
        chk("t4a_capture_end", ce_cnt - ce0, 1);
        chk("t4a_frames_done", frames_done, 2);
        chk("t4a_busy_idle", busy, 0);

        // 4b: continuous, stop while waiting for SOF
        pulse_capture();
        cam_frame(8, 1, 'h600, 1, -1, -1, -1);
        chk("t4b_frames_done_f1", frames_done, 1);
        ce0 = ce_cnt;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        chk("t4b_capture_end", ce_cnt - ce0, 1);
        chk("t4b_busy_idle", busy, 0);
        chk("t4b_frames_done", frames_done, 1);

        // 5: truncated frame then a complete one
        img_width = 16; img_height = 2; frame_count = 1;
        ce0 = ce_cnt; b0 = beats;
        pulse_capture();
        cam_frame(16, 2, 'h700, 1, 5, -1, -1);
        chk("t5_err_before", frame_err, 0);
        cam_frame(16, 2, 'h800, 1, -1, -1, -1);
        tick();
        chk("t5_frame_err", frame_err, 1);
        chk("t5_frames_done", frames_done, 1);
        chk("t5_beats", beats - b0, 13);
        chk("t5_capture_end", ce_cnt - ce0, 1);
        pulse_capture();
        chk("t5_err_cleared", frame_err, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (2) tick();

        // 6: reset during capture, then a normal run
        pulse_capture();
        cam_frame(16, 2, 'h900, 1, 1, -1, -1);
        chk("t6_vld_before_rst", bus.out_vld, 1);
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_out_vld", bus.out_vld, 0);
        chk("t6_rst_out_sof", bus.out_sof, 0);
        chk("t6_rst_busy", busy, 0);
        exp_q.delete();
        bus.cl_frame_valid = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();
        ce0 = ce_cnt; b0 = beats;
        pulse_capture();
        cam_frame(16, 2, 'hA00, 1, -1, -1, -1);
        tick();
        chk("t6_beats", beats - b0, 8);
        chk("t6_capture_end", ce_cnt - ce0, 1);
        chk("t6_frames_done", frames_done, 1);
        chk("t6_frame_err", frame_err, 0);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
